// File: rtl/bin2bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bin2bcd_seq_pkg
// Brief   : Shared types and constants for the sequential binary-to-BCD path.
// Revision: 1.0 - initial release
// ============================================================================
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_NINE    = 4'h9;

  // Enough BCD digits to hold any DATA_W-bit magnitude without wrapping.
  function automatic int int_digits(input int data_w);
    return (data_w + 2) / 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq_digit_adj.sv
`default_nettype none
// ============================================================================
// Module  : bin2bcd_seq_digit_adj
// Brief   : Add-3 correction for one BCD digit ahead of the double-dabble shift.
// Revision: 1.0 - initial release
// ============================================================================
module bin2bcd_seq_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  localparam logic [BCD_DIGIT_W-1:0] C_FIVE  = BCD_DIGIT_W'(5);
  localparam logic [BCD_DIGIT_W-1:0] C_THREE = BCD_DIGIT_W'(3);

  assign o_digit = (i_digit >= C_FIVE) ? (i_digit + C_THREE) : i_digit;

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : bin2bcd_seq
// Brief   : Sequential signed/unsigned binary to sign + BCD converter with
//           saturation to all nines when the value exceeds DIGITS digits.
// Revision: 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIGITS = 3
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  in_signed,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic                  overflow
);

  localparam int INT_DIGITS = int_digits(DATA_W);
  localparam int SCR_W      = BCD_DIGIT_W * INT_DIGITS;
  localparam int OUT_W      = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W      = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(DATA_W - 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_mag;
  logic              r_signed;
  logic              r_neg;
  logic              r_nonzero;
  logic [SCR_W-1:0]  r_scratch;
  logic [CNT_W-1:0]  r_iter;

  logic [SCR_W-1:0]  w_adj;
  logic [OUT_W-1:0]  w_bcd;
  logic              w_overflow;

  generate
    for (genvar gi = 0; gi < INT_DIGITS; gi++) begin : g_adj
      bin2bcd_seq_digit_adj u_adj (
        .i_digit (r_scratch[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .o_digit (w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Digits above the presented window only ever signal saturation.
  always_comb begin
    w_overflow = 1'b0;
    w_bcd      = '0;
    for (int i = DIGITS; i < INT_DIGITS; i++) begin
      w_overflow = w_overflow | (r_scratch[i*BCD_DIGIT_W +: BCD_DIGIT_W] != '0);
    end
    for (int i = 0; (i < DIGITS) && (i < INT_DIGITS); i++) begin
      w_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] = r_scratch[i*BCD_DIGIT_W +: BCD_DIGIT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_mag     <= '0;
      r_signed  <= 1'b0;
      r_neg     <= 1'b0;
      r_nonzero <= 1'b0;
      r_scratch <= '0;
      r_iter    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bcd       <= '0;
      sign      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mag    <= data_in;
            r_signed <= in_signed;
            in_ready <= 1'b0;
            r_state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // The most negative input negates onto itself, which read as
          // unsigned is exactly its magnitude.
          r_neg     <= r_signed & r_mag[DATA_W-1];
          r_mag     <= (r_signed & r_mag[DATA_W-1]) ? (~r_mag + DATA_W'(1)) : r_mag;
          r_nonzero <= |r_mag;
          r_scratch <= '0;
          r_iter    <= '0;
          r_state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_scratch <= {w_adj[SCR_W-2:0], r_mag[DATA_W-1]};
          r_mag     <= {r_mag[DATA_W-2:0], 1'b0};
          r_iter    <= r_iter + CNT_W'(1);
          if (r_iter == C_LAST_ITER) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          sign      <= r_neg & r_nonzero;
          overflow  <= w_overflow;
          bcd       <= w_overflow ? {DIGITS{BCD_NINE}} : w_bcd;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_bin2bcd_seq
// Brief   : Self-checking bench for bin2bcd_seq against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_signed = 1'b0;
  logic [15:0] data_in = '0;

  logic        in_ready, out_valid, sign, overflow;
  logic [11:0] bcd;
  logic        in_ready5, out_valid5, sign5, overflow5;
  logic [19:0] bcd5;

  int checks = 0;
  int failures = 0;

  logic [11:0] got_bcd;
  logic        got_sign, got_ovf;
  logic [19:0] got_bcd5;
  logic        got_sign5, got_ovf5;

  bin2bcd_seq #(.DATA_W(16), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .in_signed(in_signed),
    .in_ready(in_ready), .out_valid(out_valid), .bcd(bcd), .sign(sign), .overflow(overflow)
  );

  bin2bcd_seq #(.DATA_W(16), .DIGITS(5)) dut5 (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .in_signed(in_signed),
    .in_ready(in_ready5), .out_valid(out_valid5), .bcd(bcd5), .sign(sign5), .overflow(overflow5)
  );

  always #5 clk = ~clk;

  function automatic int ref_mag(input logic [15:0] d, input logic s);
    return (s && d[15]) ? (65536 - int'(d)) : int'(d);
  endfunction

  function automatic int ref_limit(input int nd);
    int lim;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    return lim - 1;
  endfunction

  function automatic logic [19:0] ref_bcd(input int mag, input int nd);
    logic [19:0] r;
    int v;
    r = '0;
    v = mag;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = (mag > ref_limit(nd)) ? 4'h9 : 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Runs one conversion; lat=-1 means out_valid never arrived.
  task automatic do_conv(input logic [15:0] d, input logic s,
                         output int lat, output bit narrow, output bit rdy0);
    @(negedge clk);
    start = 1'b1; data_in = d; in_signed = s;
    @(negedge clk);
    start = 1'b0; data_in = 16'($urandom); in_signed = 1'($urandom);
    rdy0 = in_ready;
    lat = -1;
    narrow = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        lat = c;
        got_bcd = bcd; got_sign = sign; got_ovf = overflow;
        got_bcd5 = bcd5; got_sign5 = sign5; got_ovf5 = overflow5;
        break;
      end
      @(negedge clk);
    end
    if (lat >= 0) begin
      @(negedge clk);
      narrow = !out_valid && !out_valid5;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, bcd, sign, overflow} !== {1'b1, 1'b0, 12'h000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b bcd=%h sign=%b ovf=%b exp rdy=1 vld=0 bcd=000 sign=0 ovf=0",
               in_ready, out_valid, bcd, sign, overflow);
    end
    checks++;
    if ({in_ready5, out_valid5, bcd5} !== {1'b1, 1'b0, 20'h0}) begin
      failures++;
      $display("FAIL reset_state5 got rdy=%b vld=%b bcd=%h exp rdy=1 vld=0 bcd=00000",
               in_ready5, out_valid5, bcd5);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat; bit narrow, rdy0;
    do_conv(16'd255, 1'b0, lat, narrow, rdy0);
    checks++;
    if (lat !== 18) begin failures++; $display("FAIL u255_latency got %0d exp 18", lat); end
    checks++;
    if (rdy0 !== 1'b0) begin failures++; $display("FAIL u255_busy got in_ready=%b exp 0", rdy0); end
    checks++;
    if ({got_bcd, got_sign, got_ovf} !== {12'h255, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL u255_result got bcd=%h sign=%b ovf=%b exp 255/0/0", got_bcd, got_sign, got_ovf);
    end
    checks++;
    if (narrow !== 1'b1) begin failures++; $display("FAIL u255_pulse_width got wide pulse exp one cycle"); end
  endtask

  task automatic test_signed();
    int lat; bit narrow, rdy0;
    do_conv(16'hFF85, 1'b1, lat, narrow, rdy0);
    checks++;
    if ({got_bcd, got_sign, got_ovf} !== {12'h123, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL s_m123 got bcd=%h sign=%b ovf=%b exp 123/1/0", got_bcd, got_sign, got_ovf);
    end
    do_conv(16'h0000, 1'b1, lat, narrow, rdy0);
    checks++;
    if ({got_bcd, got_sign, got_ovf} !== {12'h000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL s_zero got bcd=%h sign=%b ovf=%b exp 000/0/0", got_bcd, got_sign, got_ovf);
    end
  endtask

  task automatic test_saturation();
    int lat; bit narrow, rdy0;
    do_conv(16'd1000, 1'b1, lat, narrow, rdy0);
    checks++;
    if ({got_bcd, got_sign, got_ovf} !== {12'h999, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL sat_1000 got bcd=%h sign=%b ovf=%b exp 999/0/1", got_bcd, got_sign, got_ovf);
    end
    checks++;
    if ({got_bcd5, got_ovf5} !== {20'h01000, 1'b0}) begin
      failures++;
      $display("FAIL d5_1000 got bcd=%h ovf=%b exp 01000/0", got_bcd5, got_ovf5);
    end
    do_conv(16'h8000, 1'b1, lat, narrow, rdy0);
    checks++;
    if ({got_bcd, got_sign, got_ovf} !== {12'h999, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL sat_m32768 got bcd=%h sign=%b ovf=%b exp 999/1/1", got_bcd, got_sign, got_ovf);
    end
    checks++;
    if ({got_bcd5, got_sign5, got_ovf5} !== {20'h32768, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL d5_m32768 got bcd=%h sign=%b ovf=%b exp 32768/1/0", got_bcd5, got_sign5, got_ovf5);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] q[$];
    logic [16:0] e;
    logic [11:0] exp_bcd;
    int last_acc, n_out, m;
    last_acc = -1;
    n_out = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        n_out++;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL b2b_spurious got out_valid at cycle %0d exp none", cyc);
        end else begin
          e = q.pop_front();
          m = ref_mag(e[15:0], e[16]);
          exp_bcd = ref_bcd(m, 3)[11:0];
          if ({bcd, sign, overflow} !== {exp_bcd, e[16] & e[15], m > 999}) begin
            failures++;
            $display("FAIL b2b_result got bcd=%h sign=%b ovf=%b exp %h/%b/%b",
                     bcd, sign, overflow, exp_bcd, e[16] & e[15], m > 999);
          end
        end
      end
      start = (cyc < 40);
      data_in = 16'($urandom);
      in_signed = 1'($urandom);
      if (start && in_ready) begin
        q.push_back({in_signed, data_in});
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 19) begin
            failures++;
            $display("FAIL b2b_spacing got %0d cycles exp 19", cyc - last_acc);
          end
        end
        last_acc = cyc;
      end
    end
    start = 1'b0;
    checks++;
    if (n_out != 3 || q.size() != 0) begin
      failures++;
      $display("FAIL b2b_count got %0d results (%0d pending) exp 3 (0 pending)", n_out, q.size());
    end
  endtask

  task automatic test_reset_abort();
    int lat, pulses; bit narrow, rdy0;
    do_conv(16'd999, 1'b0, lat, narrow, rdy0);
    checks++;
    if (got_bcd !== 12'h999 || got_ovf !== 1'b0) begin
      failures++;
      $display("FAIL abort_pre got bcd=%h ovf=%b exp 999/0", got_bcd, got_ovf);
    end
    @(negedge clk);
    start = 1'b1; data_in = 16'hFFFF; in_signed = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, bcd, sign, overflow} !== {1'b1, 1'b0, 12'h000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL abort_clear got rdy=%b vld=%b bcd=%h sign=%b ovf=%b exp 1/0/000/0/0",
               in_ready, out_valid, bcd, sign, overflow);
    end
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL abort_no_valid got %0d pulses exp 0", pulses); end
    do_conv(16'hFE0C, 1'b1, lat, narrow, rdy0);
    checks++;
    if ({got_bcd, got_sign, got_ovf} !== {12'h500, 1'b1, 1'b0} || lat !== 18) begin
      failures++;
      $display("FAIL abort_restart got bcd=%h sign=%b ovf=%b lat=%0d exp 500/1/0 lat=18",
               got_bcd, got_sign, got_ovf, lat);
    end
  endtask

  task automatic test_random();
    logic [15:0] corners[14];
    logic [15:0] d;
    logic        s;
    logic [19:0] e3, e5;
    int lat, m, n; bit narrow, rdy0;
    corners = '{16'd0, 16'd1, 16'd9, 16'd10, 16'd99, 16'd100, 16'd999, 16'd1000,
                16'h7FFF, 16'h8000, 16'hFFFF, 16'hFC19, 16'hFC18, 16'h8001};
    n = 28 + 1200;
    for (int k = 0; k < n; k++) begin
      if (k < 28) begin
        d = corners[k/2];
        s = k[0];
      end else begin
        d = 16'($urandom);
        s = 1'($urandom);
      end
      do_conv(d, s, lat, narrow, rdy0);
      m = ref_mag(d, s);
      e3 = ref_bcd(m, 3);
      e5 = ref_bcd(m, 5);
      checks++;
      if (lat !== 18 || narrow !== 1'b1) begin
        failures++;
        $display("FAIL rnd_timing in=%h s=%b got lat=%0d narrow=%b exp 18/1", d, s, lat, narrow);
      end
      checks++;
      if ({got_bcd, got_sign, got_ovf} !== {e3[11:0], s & d[15], m > 999}) begin
        failures++;
        $display("FAIL rnd_d3 in=%h s=%b got bcd=%h sign=%b ovf=%b exp %h/%b/%b",
                 d, s, got_bcd, got_sign, got_ovf, e3[11:0], s & d[15], m > 999);
      end
      checks++;
      if ({got_bcd5, got_sign5, got_ovf5} !== {e5, s & d[15], m > 99999}) begin
        failures++;
        $display("FAIL rnd_d5 in=%h s=%b got bcd=%h sign=%b ovf=%b exp %h/%b/%b",
                 d, s, got_bcd5, got_sign5, got_ovf5, e5, s & d[15], m > 99999);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_saturation();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
